// File: rtl/dmem_pkg.sv
// ----------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the block data memory and the data cache above it.
//   DMEM_BLOCK_SIZE       : default words (32 bit) per block
//   DMEM_BLOCK_SIZE_BITS  : width of one block transfer
//   DMEM_ADDR_SIZE        : width of a block address {tag,index}
//   dmem_state_e          : controller states (IDLE, ACCESS, ACK)
//   dmem_op_e             : latched operation type
// ----------------------------------------------------------------------------
package dmem_pkg;

  localparam int DMEM_BLOCK_SIZE      = 4;
  localparam int DMEM_BLOCK_SIZE_BITS = 32 * DMEM_BLOCK_SIZE;
  localparam int DMEM_ADDR_SIZE       = 32 - $clog2(DMEM_BLOCK_SIZE);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } dmem_state_e;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } dmem_op_e;

endpackage

// File: rtl/dmem_block_array.sv
// ----------------------------------------------------------------------------
// dmem_block_array
// DEPTH x WIDTH block storage with synchronous write and synchronous,
// registered read. The storage itself has no reset; only the read register
// is cleared so the requester sees a zero block after reset.
// Ports:
//   clk_i    : clock, rising edge
//   rst_ni   : asynchronous active-low reset (read register only)
//   we_i     : write idx_i with wdata_i on the next edge
//   re_i     : load rdata_o from idx_i on the next edge
//   idx_i    : block index
//   wdata_i  : block to write
//   rdata_o  : last block read; holds until the next read
// ----------------------------------------------------------------------------
module dmem_block_array #(
  parameter int DEPTH = 256,
  parameter int WIDTH = 128
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     we_i,
  input  logic                     re_i,
  input  logic [$clog2(DEPTH)-1:0] idx_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // Block storage: written only when the controller finishes a write access.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[idx_i] <= wdata_i;
    end
  end

  // Read register: updated only by a completed read, so writes leave it alone.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[idx_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/block_data_memory.sv
// ----------------------------------------------------------------------------
// block_data_memory
// Main-memory responder for the cache block interface. A request seen in IDLE
// is latched, spends ACCESS_LATENCY cycles in ACCESS, then the array operation
// happens and BUSYWAIT drops for exactly one ACK cycle.
// Ports:
//   CLOCK       : clock, rising edge
//   RESET       : asynchronous active-low reset
//   READ_EN     : block read request, held until BUSYWAIT is seen low
//   WRITE_EN    : block write request, same hold rule (wins over READ_EN)
//   ADDR        : block address; only the low $clog2(DEPTH) bits index
//   WRITE_DATA  : block to write, word i = bits [32*i +: 32]
//   READ_DATA   : registered read block
//   BUSYWAIT    : stall to the requester
//   READ_COUNT  : completed reads  (only with DMEM_ACCESS_COUNT_EN)
//   WRITE_COUNT : completed writes (only with DMEM_ACCESS_COUNT_EN)
// Optional feature macro: DMEM_ACCESS_COUNT_EN
// ----------------------------------------------------------------------------
module block_data_memory
  import dmem_pkg::*;
#(
  parameter int BLOCK_SIZE     = DMEM_BLOCK_SIZE,
  parameter int DEPTH          = 256,
  parameter int ACCESS_LATENCY = 5
) (
  input  logic                              CLOCK,
  input  logic                              RESET,
  input  logic                              READ_EN,
  input  logic                              WRITE_EN,
  input  logic [32-$clog2(BLOCK_SIZE)-1:0]  ADDR,
  input  logic [32*BLOCK_SIZE-1:0]          WRITE_DATA,
  output logic [32*BLOCK_SIZE-1:0]          READ_DATA,
  output logic                              BUSYWAIT
`ifdef DMEM_ACCESS_COUNT_EN
  ,
  output logic [31:0]                       READ_COUNT,
  output logic [31:0]                       WRITE_COUNT
`endif
);

  localparam int BLOCK_SIZE_BITS = 32 * BLOCK_SIZE;
  localparam int MEM_ADDR_SIZE   = 32 - $clog2(BLOCK_SIZE);
  localparam int IDX_BITS        = $clog2(DEPTH);
  localparam int CNT_BITS        = $clog2(ACCESS_LATENCY + 1);

  dmem_state_e                state_q, state_d;
  logic [CNT_BITS-1:0]        count_q, count_d;
  dmem_op_e                   op_q, op_d;
  logic [IDX_BITS-1:0]        idx_q, idx_d;
  logic [BLOCK_SIZE_BITS-1:0] wdata_q, wdata_d;
  logic                       busy;
  logic                       arrayWrite;
  logic                       arrayRead;
  logic                       unusedAddrBits;

  // Upper address bits select the tag only; storage wraps modulo DEPTH.
  assign unusedAddrBits = ^ADDR[MEM_ADDR_SIZE-1:IDX_BITS];

  // Controller state and the request latched at the IDLE->ACCESS edge.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state_q <= IDLE;
      count_q <= '0;
      op_q    <= OP_READ;
      idx_q   <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      op_q    <= op_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
    end
  end

  // Next state and stall. BUSYWAIT in IDLE follows the enables directly so
  // the requester stalls in the cycle it asserts; it is gated by RESET so a
  // requester still holding its enable sees no stall while reset is active.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    op_d       = op_q;
    idx_d      = idx_q;
    wdata_d    = wdata_q;
    busy       = 1'b0;
    arrayWrite = 1'b0;
    arrayRead  = 1'b0;
    case (state_q)
      IDLE: begin
        busy = (READ_EN | WRITE_EN) & RESET;
        if (READ_EN | WRITE_EN) begin
          op_d    = WRITE_EN ? OP_WRITE : OP_READ;
          idx_d   = ADDR[IDX_BITS-1:0];
          wdata_d = WRITE_DATA;
          count_d = CNT_BITS'(ACCESS_LATENCY - 1);
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        busy = 1'b1;
        if (count_q != '0) begin
          count_d = count_q - CNT_BITS'(1);
        end else begin
          arrayWrite = (op_q == OP_WRITE);
          arrayRead  = (op_q == OP_READ);
          state_d    = ACK;
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign BUSYWAIT = busy;

  dmem_block_array #(
    .DEPTH (DEPTH),
    .WIDTH (BLOCK_SIZE_BITS)
  ) u_array (
    .clk_i   (CLOCK),
    .rst_ni  (RESET),
    .we_i    (arrayWrite),
    .re_i    (arrayRead),
    .idx_i   (idx_q),
    .wdata_i (wdata_q),
    .rdata_o (READ_DATA)
  );

`ifdef DMEM_ACCESS_COUNT_EN
  logic [31:0] readCount_q;
  logic [31:0] writeCount_q;

  // Completed-access counters; they advance on the ACCESS->ACK edge only, so
  // a transaction cut short by reset is never counted.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      readCount_q  <= '0;
      writeCount_q <= '0;
    end else begin
      if (arrayRead) begin
        readCount_q <= readCount_q + 32'd1;
      end
      if (arrayWrite) begin
        writeCount_q <= writeCount_q + 32'd1;
      end
    end
  end

  assign READ_COUNT  = readCount_q;
  assign WRITE_COUNT = writeCount_q;
`else
  // Without the counters the access path above is the whole design.
`endif

endmodule
